// File: rtl/ram_io_streamer_if.sv
// Pixel-in, result-out and RAM port bundle of the ram_io_streamer.
// master is the streamer side, slave the surrounding system.
interface ram_io_streamer_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 16
) ();
   logic              Load_Start;
   logic              Out_Req;
   logic              In_Valid;
   logic              In_Ready;
   logic [DATA_W-1:0] In_Data;
   logic              Out_Valid;
   logic              Out_Ready;
   logic [DATA_W-1:0] Out_Data;
   logic              Out_Last;
   logic              Load_Done;
   logic              Busy;
   logic              Ram_Wren;
   logic [ADDR_W-1:0] Ram_Address;
   logic [DATA_W-1:0] Ram_D;
   logic [DATA_W-1:0] Ram_Q;

   modport master (
      input  Load_Start, Out_Req, In_Valid, In_Data,
      input  Out_Ready, Ram_Q,
      output In_Ready, Out_Valid, Out_Data, Out_Last,
      output Load_Done, Busy, Ram_Wren, Ram_Address, Ram_D
   );

   modport slave (
      output Load_Start, Out_Req, In_Valid, In_Data,
      output Out_Ready, Ram_Q,
      input  In_Ready, Out_Valid, Out_Data, Out_Last,
      input  Load_Done, Busy, Ram_Wren, Ram_Address, Ram_D
   );
endinterface

// File: rtl/ram_io_streamer.sv
// Owns the single-port I/O RAM: streams an image in at address 0 and
// streams the result region back out, absorbing read latency and backpressure.
module ram_io_streamer #(
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 16,
   parameter int LOAD_WORDS = 784,
   parameter int OUT_BASE   = 784,
   parameter int OUT_WORDS  = 10,
   parameter int RD_LAT     = 2
) (
   input logic             Clk,
   input logic             Reset,
   ram_io_streamer_if.master io
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      RD_ISSUE,
      RD_WAIT,
      RD_PRESENT
   } state_e;

   if (LOAD_WORDS > OUT_BASE ||
       OUT_BASE + OUT_WORDS > 2 ** ADDR_W ||
       RD_LAT < 1 || RD_LAT > 2) begin : g_param_chk
      $error("ram_io_streamer: illegal parameter set");
   end

   localparam logic [ADDR_W-1:0] LastLoad = ADDR_W'(LOAD_WORDS - 1);
   localparam logic [ADDR_W-1:0] LastOut  = ADDR_W'(OUT_WORDS - 1);
   localparam logic [ADDR_W-1:0] Base     = ADDR_W'(OUT_BASE);
   localparam logic [ADDR_W-1:0] One      = ADDR_W'(1);
   localparam logic [1:0]        LatEnd   = 2'(RD_LAT - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [1:0]        lat_q, lat_d;
   logic              wren_q, wren_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              ovalid_q, ovalid_d;
   logic [DATA_W-1:0] odata_q, odata_d;
   logic              olast_q, olast_d;
   logic              done_q, done_d;
   logic              in_ready;

   assign in_ready = (state_q == LOAD);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      lat_d    = lat_q;
      wren_d   = 1'b0;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      ovalid_d = ovalid_q;
      odata_d  = odata_q;
      olast_d  = olast_q;
      done_d   = done_q;
      unique case (state_q)
         IDLE: begin
            if (io.Load_Start) begin
               state_d = LOAD;
               cnt_d   = '0;
               done_d  = 1'b0;
            end else if (io.Out_Req) begin
               state_d = RD_ISSUE;
               idx_d   = '0;
               addr_d  = Base;
            end
         end
         LOAD: begin
            if (io.In_Valid && in_ready) begin
               wren_d  = 1'b1;
               addr_d  = cnt_q;
               wdata_d = io.In_Data;
               cnt_d   = cnt_q + One;
               if (cnt_q == LastLoad) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         RD_ISSUE: begin
            lat_d   = 2'd0;
            state_d = RD_WAIT;
         end
         RD_WAIT: begin
            // Ram_Q is usable in the last wait cycle only
            if (lat_q == LatEnd) begin
               odata_d  = io.Ram_Q;
               olast_d  = (idx_q == LastOut);
               ovalid_d = 1'b1;
               state_d  = RD_PRESENT;
            end else begin
               lat_d = lat_q + 2'd1;
            end
         end
         RD_PRESENT: begin
            if (io.Out_Ready) begin
               ovalid_d = 1'b0;
               if (idx_q == LastOut) begin
                  state_d = IDLE;
                  olast_d = 1'b0;
               end else begin
                  idx_d   = idx_q + One;
                  addr_d  = Base + idx_q + One;
                  state_d = RD_ISSUE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         lat_q    <= '0;
         wren_q   <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         ovalid_q <= 1'b0;
         odata_q  <= '0;
         olast_q  <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         lat_q    <= lat_d;
         wren_q   <= wren_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         ovalid_q <= ovalid_d;
         odata_q  <= odata_d;
         olast_q  <= olast_d;
         done_q   <= done_d;
      end
   end

   assign io.In_Ready    = in_ready;
   assign io.Busy        = (state_q != IDLE);
   assign io.Ram_Wren    = wren_q;
   assign io.Ram_Address = addr_q;
   assign io.Ram_D       = wdata_q;
   assign io.Out_Valid   = ovalid_q;
   assign io.Out_Data    = odata_q;
   assign io.Out_Last    = olast_q;
   assign io.Load_Done   = done_q;

endmodule

// File: tb/tb_ram_io_streamer.sv
// Scoreboard bench: dut0 runs RD_LAT=2, dut1 RD_LAT=1 on shared stimulus.
// Drivers push expected writes/results; negedge monitors pop and compare.
module tb_ram_io_streamer;

   localparam int LW = 784;
   localparam int OB = 784;
   localparam int OW = 10;

   typedef struct packed {
      logic [9:0]  a;
      logic [15:0] d;
   } wr_t;

   typedef struct packed {
      logic [15:0] d;
      logic        l;
      logic [9:0]  a;
      int          c;
   } res_t;

   logic Clk = 1'b0;
   logic Reset = 1'b1;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;

   wr_t  qw[$];
   res_t qr0[$];
   res_t qr1[$];
   wr_t  ew;
   res_t er0, er1;
   logic hs_prev = 1'b0;

   logic [15:0] mem0[1024];
   logic [15:0] mem1[1024];
   logic [9:0]  a0;
   logic [15:0] q0, q1;

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   ram_io_streamer_if #(.ADDR_W(10), .DATA_W(16)) b0 ();
   ram_io_streamer_if #(.ADDR_W(10), .DATA_W(16)) b1 ();

   ram_io_streamer #(.RD_LAT(2)) u_dut0 (
      .Clk(Clk), .Reset(Reset), .io(b0.master)
   );
   ram_io_streamer #(.RD_LAT(1)) u_dut1 (
      .Clk(Clk), .Reset(Reset), .io(b1.master)
   );

   assign b1.Load_Start = b0.Load_Start;
   assign b1.Out_Req    = b0.Out_Req;
   assign b1.In_Valid   = b0.In_Valid;
   assign b1.In_Data    = b0.In_Data;
   assign b1.Out_Ready  = 1'b1;
   assign b0.Ram_Q      = q0;
   assign b1.Ram_Q      = q1;

   // RAM models: result region preloaded while Reset is high
   always @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < OW; i++) begin
            mem0[OB+i] <= 16'(16'h0100 + i);
            mem1[OB+i] <= 16'(16'h0100 + i);
         end
      end else begin
         if (b0.Ram_Wren) mem0[b0.Ram_Address] <= b0.Ram_D;
         if (b1.Ram_Wren) mem1[b1.Ram_Address] <= b1.Ram_D;
      end
      a0 <= b0.Ram_Address;
      q0 <= mem0[a0];
      q1 <= mem1[b1.Ram_Address];
   end

   task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   always @(negedge Clk) begin
      if (b0.Ram_Wren || hs_prev) begin
         tests++;
         if (!(b0.Ram_Wren && hs_prev && qw.size() > 0)) begin
            fails++;
            $display("FAIL wr_timing wren=%0b hs_prev=%0b pending=%0d",
                     b0.Ram_Wren, hs_prev, qw.size());
         end else begin
            ew = qw.pop_front();
            if ({b0.Ram_Address, b0.Ram_D} !== ew) begin
               fails++;
               $display("FAIL wr_data got a=%0d d=%0h exp a=%0d d=%0h",
                        b0.Ram_Address, b0.Ram_D, ew.a, ew.d);
            end
         end
      end
      hs_prev = !Reset && b0.In_Valid && b0.In_Ready;
   end

   always @(negedge Clk) begin
      if (b0.Out_Valid) begin
         tests++;
         if (qr0.size() == 0) begin
            fails++;
            $display("FAIL rd0_unexpected got d=%0h exp none", b0.Out_Data);
         end else begin
            er0 = qr0[0];
            if ({b0.Out_Data, b0.Out_Last, b0.Ram_Address} !==
                {er0.d, er0.l, er0.a}) begin
               fails++;
               $display("FAIL rd0_word got d=%0h l=%0b a=%0d exp d=%0h l=%0b a=%0d",
                        b0.Out_Data, b0.Out_Last, b0.Ram_Address,
                        er0.d, er0.l, er0.a);
            end
            if (b0.Out_Ready) begin
               tests++;
               if (cyc != er0.c) begin
                  fails++;
                  $display("FAIL rd0_cycle got=%0d exp=%0d", cyc, er0.c);
               end
               er0 = qr0.pop_front();
            end
         end
      end
   end

   always @(negedge Clk) begin
      if (b1.Out_Valid) begin
         tests++;
         if (qr1.size() == 0) begin
            fails++;
            $display("FAIL rd1_unexpected got d=%0h exp none", b1.Out_Data);
         end else begin
            er1 = qr1.pop_front();
            if ({b1.Out_Data, b1.Out_Last, b1.Ram_Address} !==
                {er1.d, er1.l, er1.a} || cyc != er1.c) begin
               fails++;
               $display("FAIL rd1_word got d=%0h l=%0b a=%0d c=%0d exp d=%0h l=%0b a=%0d c=%0d",
                        b1.Out_Data, b1.Out_Last, b1.Ram_Address, cyc,
                        er1.d, er1.l, er1.a, er1.c);
            end
         end
      end
   end

   task automatic do_load(int n, bit rnd, int abort_at, bit with_req);
      int          k = 0;
      int          guard = 0;
      bit          first = 1'b1;
      logic [15:0] dat;
      @(posedge Clk); #1;
      b0.Load_Start = 1'b1;
      b0.Out_Req    = with_req;
      @(posedge Clk); #1;
      b0.Load_Start = 1'b0;
      b0.Out_Req    = 1'b0;
      while (k < n && k != abort_at && guard < 4000) begin
         dat = rnd ? 16'(k * 37 + 16'h1234) : 16'(k);
         b0.In_Valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         b0.In_Data  = dat;
         @(negedge Clk);
         if (first) begin
            chk("load_entry", {b0.In_Ready, b0.Busy, b0.Load_Done}, 3'b110);
            first = 1'b0;
         end
         if (b0.In_Valid && b0.In_Ready) begin
            qw.push_back({10'(k), dat});
            k++;
         end
         guard++;
         @(posedge Clk); #1;
      end
      chk("load_count", k, (abort_at >= 0) ? abort_at : n);
      if (abort_at >= 0 && k == abort_at) begin
         b0.In_Valid = 1'b1;
         Reset = 1'b1;
         @(posedge Clk); #1;
         Reset = 1'b0;
         b0.In_Valid = 1'b0;
         @(negedge Clk);
         chk("abort_state", {b0.Load_Done, b0.Ram_Wren, b0.Busy,
                             b0.In_Ready, b0.Out_Valid}, 0);
      end else begin
         b0.In_Valid = 1'b0;
         @(negedge Clk);
         chk("load_done", {b0.Load_Done, b0.In_Ready, b0.Busy}, 3'b100);
      end
   endtask

   task automatic readback(int stall);
      int r;
      int p3;
      int guard = 0;
      @(posedge Clk); #1;
      r = cyc;
      b0.Out_Req   = 1'b1;
      b0.Out_Ready = 1'b1;
      for (int i = 0; i < OW; i++) begin
         qr0.push_back('{16'(16'h0100 + i), (i == OW - 1), 10'(OB + i),
                         r + 4 + 4 * i + ((i >= 3) ? stall : 0)});
         qr1.push_back('{16'(16'h0100 + i), (i == OW - 1), 10'(OB + i),
                         r + 3 + 3 * i});
      end
      p3 = r + 4 + 12;
      @(posedge Clk); #1;
      b0.Out_Req = 1'b0;
      while ((qr0.size() != 0 || qr1.size() != 0) && guard < 200) begin
         b0.Out_Ready = !(cyc >= p3 && cyc < p3 + stall);
         @(posedge Clk); #1;
         guard++;
      end
      chk("rd_timeout", guard < 200, 1);
      b0.Out_Ready = 1'b1;
      @(negedge Clk);
      chk("rd_idle", {b0.Busy, b0.Out_Valid, b0.Out_Last,
                      b1.Busy, b1.Out_Valid}, 0);
   endtask

   initial begin
      b0.Load_Start = 1'b0;
      b0.Out_Req    = 1'b0;
      b0.In_Valid   = 1'b0;
      b0.In_Data    = '0;
      b0.Out_Ready  = 1'b1;
      Reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         b0.Load_Start = 1'($urandom_range(0, 1));
         b0.Out_Req    = 1'($urandom_range(0, 1));
         b0.In_Valid   = 1'($urandom_range(0, 1));
         b0.In_Data    = 16'($urandom);
         b0.Out_Ready  = 1'($urandom_range(0, 1));
         @(posedge Clk);
         @(negedge Clk);
         chk("reset_out0", {b0.Out_Valid, b0.Out_Data, b0.Out_Last,
                            b0.Load_Done, b0.Busy, b0.In_Ready,
                            b0.Ram_Wren, b0.Ram_Address, b0.Ram_D}, 0);
         chk("reset_out1", {b1.Out_Valid, b1.Out_Data, b1.Out_Last,
                            b1.Load_Done, b1.Busy, b1.In_Ready,
                            b1.Ram_Wren, b1.Ram_Address, b1.Ram_D}, 0);
      end
      b0.Load_Start = 1'b0;
      b0.Out_Req    = 1'b0;
      b0.In_Valid   = 1'b0;
      b0.In_Data    = '0;
      b0.Out_Ready  = 1'b1;
      Reset = 1'b0;

      do_load(LW, 1'b0, -1, 1'b0);
      do_load(LW, 1'b1, -1, 1'b0);
      readback(0);
      readback(5);
      do_load(LW, 1'b0, 100, 1'b0);
      do_load(LW, 1'b0, -1, 1'b1);
      repeat (12) @(posedge Clk);
      @(negedge Clk);
      chk("wr_pending", qw.size(), 0);
      chk("rd_pending", qr0.size() + qr1.size(), 0);
      chk("final_idle", {b0.Busy, b0.Out_Valid, b1.Busy, b1.Out_Valid}, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ram_io_streamer.md
Name: ram_io_streamer

Overview:
Sequencer that owns the port of the single-port input/output RAM (10-bit address, 16-bit data). It loads an input image from a valid/ready pixel stream into RAM addresses 0..LOAD_WORDS-1. It reads the network's result words back out of the output region onto a valid/ready stream. It is the initiator side of the RAM interface, and it absorbs the RAM read latency and downstream backpressure.

Parameters:
ADDR_W, 10, RAM address width
DATA_W, 16, RAM word width
LOAD_WORDS, 784, words written per load (28x28 image)
OUT_BASE, 784, first RAM address of the result region
OUT_WORDS, 10, result words read per readback
RD_LAT, 2, clock edges from address sampled by RAM to Ram_Q usable (1 or 2)

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
Load_Start  in  1  pulse: begin a load (honoured in IDLE only)
Out_Req  in  1  pulse: begin a readback (honoured in IDLE only)
In_Valid  in  1  pixel stream valid
In_Ready  out  1  pixel stream ready
In_Data  in  DATA_W  pixel word
Out_Valid  out  1  result stream valid
Out_Ready  in  1  result stream ready
Out_Data  out  DATA_W  result word
Out_Last  out  1  marks final result word
Load_Done  out  1  sticky: a full load completed
Busy  out  1  state != IDLE
Ram_Wren  out  1  RAM write enable
Ram_Address  out  ADDR_W  RAM address
Ram_D  out  DATA_W  RAM write data
Ram_Q  in  DATA_W  RAM read data

Behaviour:
- Reset: state IDLE. All outputs 0. Word/index counters 0. Reset overrides every other input in the same cycle.
- All outputs are registered. The only exceptions are In_Ready and Busy, which are decoded from the state register.
- States: IDLE, LOAD, RD_ISSUE, RD_WAIT, RD_PRESENT.
- IDLE:
  - Load_Start -> LOAD, load counter cleared, Load_Done cleared.
  - Out_Req (with Load_Start low) -> RD_ISSUE, result index cleared.
  - Both asserted together: Load_Start wins and Out_Req is dropped.
  - Either pulse outside IDLE is ignored.
- LOAD:
  - In_Ready=1.
  - Handshake (In_Valid & In_Ready) in cycle t: in cycle t+1, Ram_Wren=1, Ram_Address=count, Ram_D=In_Data; count increments.
  - No handshake: Ram_Wren=0 next cycle.
  - Handshake number LOAD_WORDS -> IDLE, Load_Done=1 from the next cycle, In_Ready=0 from the next cycle. The last write still issues in that cycle.
- RD_ISSUE (1 cycle, cycle t): Ram_Wren=0, Ram_Address=OUT_BASE+idx valid during t. Next state RD_WAIT.
- RD_WAIT (RD_LAT cycles, t+1..t+RD_LAT): at the end of the last cycle, Out_Data<=Ram_Q and Out_Last<=(idx==OUT_WORDS-1). Next state RD_PRESENT.
- RD_PRESENT:
  - Out_Valid=1 from cycle t+RD_LAT+1.
  - Out_Data and Out_Last are held stable while Out_Ready=0. No new RAM read is issued.
  - On Out_Ready, Out_Valid drops next cycle.
  - If idx==OUT_WORDS-1 -> IDLE, Out_Last cleared.
  - Otherwise idx++ -> RD_ISSUE.
- Throughput: minimum 2+RD_LAT cycles per result word.
- Ram_Wren is never 1 outside the cycle following a LOAD handshake.
- Address arithmetic is modulo 2^ADDR_W. The parameters must satisfy LOAD_WORDS<=OUT_BASE and OUT_BASE+OUT_WORDS<=2^ADDR_W; checked by elaboration assertion.
- Reset mid-LOAD or mid-readback:
  - Abort immediately to IDLE; Load_Done=0; Out_Valid=0; Ram_Wren=0 from the cycle after Reset is sampled.
  - A partially written image is not cleared.
  - The next Load_Start restarts at address 0.

Test Plan:
1. Reset asserted 3 cycles with random inputs -> all outputs 0, Busy=0, no Ram_Wren pulses.
2. Load_Start, then 784 back-to-back words In_Data=i -> exactly 784 Ram_Wren pulses at addresses 0..783 with Ram_D=address. Load_Done=1 and In_Ready=0 one cycle after the 784th handshake.
3. Load with In_Valid toggled by pseudo-random pattern (about 50% duty) -> one write per handshake, consecutive addresses with no gaps or duplicates, Ram_Wren=0 on non-handshake cycles.
4. RAM model with RD_LAT=2, words 784..793 preloaded 0x0100+i, Out_Ready held 1 -> Out_Data 0x0100..0x0109 in order at 4-cycle spacing, Out_Last only on 0x0109, then Busy=0. Repeat with RD_LAT=1 -> 3-cycle spacing.
5. Out_Ready held 0 for 5 cycles while word 3 is presented -> Out_Data=0x0103 stable, Ram_Address unchanged, no extra reads. Sequence resumes correctly.
6. Reset after 100 load handshakes -> IDLE, Load_Done=0, Ram_Wren=0 next cycle. Load_Start and Out_Req in the same cycle -> LOAD entered, first write at address 0, no readback occurs.
